// File: rtl/tpu_job_controller.sv
// tpu_job_controller: sequences one TPU job.
// Flow: host bytes -> weight memory -> unified buffer -> compute pulse ->
// wait for completion -> read result memory -> stream results to the host.
//
// Handshake rule for both streams: a word moves on a rising edge where
// valid and ready are both high. The host may drop valid at any time and the
// sink may drop ready at any time. While valid is high and ready is low, the
// controller holds out_data and out_valid steady.
module tpu_job_controller #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int ADDR_W = 4,
  parameter int N_W    = 4,
  parameter int N_X    = 4,
  parameter int N_OUT  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_valid,
  output logic              host_ready,
  output logic              wmem_we,
  output logic [ADDR_W-1:0] wmem_addr,
  output logic [DATA_W-1:0] wmem_wdata,
  output logic              umem_we,
  output logic [ADDR_W-1:0] umem_addr,
  output logic [DATA_W-1:0] umem_wdata,
  output logic              compute_start,
  input  logic              compute_done,
  output logic              res_rd_en,
  output logic [ADDR_W-1:0] res_addr,
  input  logic [ACC_W-1:0]  res_data,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [3:0]        dbg_state
);

  localparam int N_WX  = (N_W > N_X) ? N_W : N_X;
  localparam int N_MAX = (N_WX > N_OUT) ? N_WX : N_OUT;
  localparam int CNT_W = $clog2(N_MAX) + 1;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD_W = 4'd1,
    S_LOAD_X = 4'd2,
    S_FLUSH  = 4'd3,
    S_FIRE   = 4'd4,
    S_WAIT   = 4'd5,
    S_RD_REQ = 4'd6,
    S_RD_CAP = 4'd7,
    S_OUT    = 4'd8,
    S_FIN    = 4'd9
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               xfer;
  logic               wmem_we_n, umem_we_n;
  logic [ADDR_W-1:0]  wmem_addr_n, umem_addr_n, res_addr_n;
  logic [DATA_W-1:0]  wmem_wdata_n, umem_wdata_n;
  logic [ACC_W-1:0]   out_data_n;

  assign dbg_state = state;

  // State, counter and registered memory-port / result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      wmem_we    <= 1'b0;
      wmem_addr  <= '0;
      wmem_wdata <= '0;
      umem_we    <= 1'b0;
      umem_addr  <= '0;
      umem_wdata <= '0;
      res_addr   <= '0;
      out_data   <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      wmem_we    <= wmem_we_n;
      wmem_addr  <= wmem_addr_n;
      wmem_wdata <= wmem_wdata_n;
      umem_we    <= umem_we_n;
      umem_addr  <= umem_addr_n;
      umem_wdata <= umem_wdata_n;
      res_addr   <= res_addr_n;
      out_data   <= out_data_n;
    end
  end

  // Next-state logic, next values for the registered ports, and the
  // state-decoded strobes. Write strobes default low; addr/data hold.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    wmem_we_n     = 1'b0;
    wmem_addr_n   = wmem_addr;
    wmem_wdata_n  = wmem_wdata;
    umem_we_n     = 1'b0;
    umem_addr_n   = umem_addr;
    umem_wdata_n  = umem_wdata;
    res_addr_n    = res_addr;
    out_data_n    = out_data;
    host_ready    = (state == S_LOAD_W) || (state == S_LOAD_X);
    compute_start = (state == S_FIRE);
    res_rd_en     = (state == S_RD_REQ);
    out_valid     = (state == S_OUT);
    busy          = (state != S_IDLE);
    done          = (state == S_FIN);
    xfer          = host_valid && host_ready;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_LOAD_W;
          cnt_n   = '0;
        end
      end
      S_LOAD_W: begin
        if (xfer) begin
          wmem_we_n    = 1'b1;
          wmem_addr_n  = ADDR_W'(cnt);
          wmem_wdata_n = host_data;
          if (cnt == CNT_W'(N_W - 1)) begin
            state_n = S_LOAD_X;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      S_LOAD_X: begin
        if (xfer) begin
          umem_we_n    = 1'b1;
          umem_addr_n  = ADDR_W'(cnt);
          umem_wdata_n = host_data;
          if (cnt == CNT_W'(N_X - 1)) begin
            state_n = S_FLUSH;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      // Lets the final activation write land before compute starts.
      S_FLUSH: state_n = S_FIRE;
      S_FIRE:  state_n = S_WAIT;
      S_WAIT: begin
        if (compute_done) begin
          state_n    = S_RD_REQ;
          cnt_n      = '0;
          res_addr_n = '0;
        end
      end
      S_RD_REQ: state_n = S_RD_CAP;
      // Read data is valid one cycle after the request.
      S_RD_CAP: begin
        out_data_n = res_data;
        state_n    = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          if (cnt == CNT_W'(N_OUT - 1)) begin
            state_n = S_FIN;
          end else begin
            cnt_n      = cnt + 1'b1;
            res_addr_n = ADDR_W'(cnt + 1'b1);
            state_n    = S_RD_REQ;
          end
        end
      end
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

endmodule
